// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } timer_state_e;

    localparam int unsigned MIN_PRESCALE_SINGLE = 2;
    localparam int unsigned MIN_PRESCALE_MAJ3   = 4;

    localparam logic [1:0] SAMPLE_IDX_NONE  = 2'd0;
    localparam logic [1:0] SAMPLE_IDX_EARLY = 2'd0;
    localparam logic [1:0] SAMPLE_IDX_MID   = 2'd1;
    localparam logic [1:0] SAMPLE_IDX_LATE  = 2'd2;

endpackage

// File: rtl/uart_rx_edge_bit_timer.sv
// Oversampling edge/bit timer for the UART receiver with per-frame latched configuration.
// Optional macro UART_RX_MAJ3_EN: three sample strobes per bit for majority voting.
module uart_rx_edge_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_bits,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sample_stb,
    output logic [1:0]            sample_idx,
    output logic                  bit_stb,
    output logic                  frame_done,
    output logic                  cfg_err
);

`ifdef UART_RX_MAJ3_EN
    localparam int unsigned MIN_P = MIN_PRESCALE_MAJ3;
`else
    localparam int unsigned MIN_P = MIN_PRESCALE_SINGLE;
`endif

    localparam logic [PRESCALE_W-1:0] P_ONE = 1;
    localparam logic [BIT_CNT_W-1:0]  B_ONE = 1;

    timer_state_e          state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic [BIT_CNT_W-1:0]  f_q, f_d;
    logic                  cfg_err_q, cfg_err_d;

    logic                  running;
    logic                  last_edge;
    logic                  last_bit;
    logic                  cfg_legal;
    logic [PRESCALE_W-1:0] mid;

    assign running   = (state_q == ST_RUN);
    assign mid       = p_q >> 1;
    assign last_edge = (edge_q == (p_q - P_ONE));
    assign last_bit  = (bit_q == (f_q - B_ONE));
    assign cfg_legal = (prescale >= PRESCALE_W'(MIN_P)) && (frame_bits != '0);

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        p_d       = p_q;
        f_d       = f_q;
        cfg_err_d = cfg_err_q;
        if (!enable) begin
            state_d   = ST_IDLE;
            edge_d    = '0;
            bit_d     = '0;
            cfg_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    p_d    = prescale;
                    f_d    = frame_bits;
                    edge_d = '0;
                    bit_d  = '0;
                    if (cfg_legal) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d   = ST_HOLD;
                        cfg_err_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last_edge) begin
                        edge_d = '0;
                        if (last_bit) begin
                            state_d = ST_HOLD;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + B_ONE;
                        end
                    end else begin
                        edge_d = edge_q + P_ONE;
                    end
                end
                ST_HOLD: begin
                    edge_d = '0;
                    bit_d  = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            p_q       <= '0;
            f_q       <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            p_q       <= p_d;
            f_q       <= f_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Strobes decode only the latched P/F, so a mid-frame prescale change is invisible.
    assign bit_stb    = running && last_edge;
    assign frame_done = bit_stb && last_bit;

`ifdef UART_RX_MAJ3_EN
    always_comb begin
        sample_stb = 1'b0;
        sample_idx = SAMPLE_IDX_NONE;
        if (running) begin
            if (edge_q == (mid - P_ONE)) begin
                sample_stb = 1'b1;
                sample_idx = SAMPLE_IDX_EARLY;
            end else if (edge_q == mid) begin
                sample_stb = 1'b1;
                sample_idx = SAMPLE_IDX_MID;
            end else if (edge_q == (mid + P_ONE)) begin
                sample_stb = 1'b1;
                sample_idx = SAMPLE_IDX_LATE;
            end
        end
    end
`else
    assign sample_stb = running && (edge_q == mid);
    assign sample_idx = sample_stb ? SAMPLE_IDX_MID : SAMPLE_IDX_NONE;
`endif

    assign edge_cnt = edge_q;
    assign bit_cnt  = bit_q;
    assign cfg_err  = cfg_err_q;

endmodule
